// File: rtl/ml_acc_axil_regs_if.sv
// AXI4-Lite bus bundle between the GP0 interconnect and the accelerator register file.
interface ml_acc_axil_regs_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0]   s_axi_awaddr;
  logic                s_axi_awvalid;
  logic                s_axi_awready;
  logic [DATA_W-1:0]   s_axi_wdata;
  logic [DATA_W/8-1:0] s_axi_wstrb;
  logic                s_axi_wvalid;
  logic                s_axi_wready;
  logic [1:0]          s_axi_bresp;
  logic                s_axi_bvalid;
  logic                s_axi_bready;
  logic [ADDR_W-1:0]   s_axi_araddr;
  logic                s_axi_arvalid;
  logic                s_axi_arready;
  logic [DATA_W-1:0]   s_axi_rdata;
  logic [1:0]          s_axi_rresp;
  logic                s_axi_rvalid;
  logic                s_axi_rready;

  modport master (
    output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

  modport slave (
    input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );
endinterface

// File: rtl/ml_acc_axil_regs.sv
// ML accelerator control/status register file behind an AXI4-Lite slave port.
// Issues a one-cycle start pulse to the conv core and captures its result word.
module ml_acc_axil_regs #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  ml_acc_axil_regs_if.slave axi,
  output logic              start_o,
  input  logic              busy_i,
  input  logic              done_i,
  input  logic              result_valid_i,
  input  logic [DATA_W-1:0] result_i,
  output logic [DATA_W-1:0] cfg_in_len_o,
  output logic [DATA_W-1:0] cfg_w_len_o
);
  localparam int IDX_W  = ADDR_W - 2;
  localparam int STRB_W = DATA_W / 8;
  localparam int RW_LO  = 2;
  localparam int RW_HI  = 9;
  localparam logic [IDX_W-1:0] IDX_RESULT = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_STATUS = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_CTRL   = IDX_W'(10);

  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_COMMIT, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA} r_state_t;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } wr_req_t;

  w_state_t w_st, w_nxt;
  r_state_t r_st, r_nxt;
  logic     aw_got, w_got, aw_got_nxt, w_got_nxt;
  logic     awready_q, wready_q, bvalid_q;
  logic     arready_q, rvalid_q;
  logic     aw_hs, w_hs, ar_hs, commit;
  logic     start_fire, done_clr, done_q;
  wr_req_t  req_q;

  logic [DATA_W-1:0]                 result_q, rdata_q, rd_word;
  logic [RW_HI:RW_LO][DATA_W-1:0]    rw_q;
  logic [IDX_W-1:0]                  rd_idx;
  logic                              unused_addr_bits;

  assign aw_hs  = axi.s_axi_awvalid & awready_q;
  assign w_hs   = axi.s_axi_wvalid & wready_q;
  assign ar_hs  = axi.s_axi_arvalid & arready_q;
  assign rd_idx = axi.s_axi_araddr[ADDR_W-1:2];
  assign unused_addr_bits = ^{axi.s_axi_awaddr[1:0], axi.s_axi_araddr[1:0]};

  // Write channel: AW and W are collected independently, then committed together.
  always_comb begin
    w_nxt      = w_st;
    aw_got_nxt = aw_got;
    w_got_nxt  = w_got;
    commit     = 1'b0;
    case (w_st)
      W_IDLE, W_WAIT: begin
        if (aw_hs) aw_got_nxt = 1'b1;
        if (w_hs)  w_got_nxt  = 1'b1;
        if (aw_got_nxt && w_got_nxt)      w_nxt = W_COMMIT;
        else if (aw_got_nxt || w_got_nxt) w_nxt = W_WAIT;
      end
      W_COMMIT: begin
        commit     = 1'b1;
        aw_got_nxt = 1'b0;
        w_got_nxt  = 1'b0;
        w_nxt      = W_RESP;
      end
      W_RESP:  if (axi.s_axi_bready) w_nxt = W_IDLE;
      default: w_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_st      <= W_IDLE;
      aw_got    <= 1'b0;
      w_got     <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      w_st      <= w_nxt;
      aw_got    <= aw_got_nxt;
      w_got     <= w_got_nxt;
      awready_q <= (w_nxt == W_IDLE || w_nxt == W_WAIT) && !aw_got_nxt;
      wready_q  <= (w_nxt == W_IDLE || w_nxt == W_WAIT) && !w_got_nxt;
      bvalid_q  <= (w_nxt == W_RESP);
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      req_q <= '0;
    end else begin
      if (aw_hs) req_q.idx <= axi.s_axi_awaddr[ADDR_W-1:2];
      if (w_hs) begin
        req_q.data <= axi.s_axi_wdata;
        req_q.strb <= axi.s_axi_wstrb;
      end
    end
  end

  // Control/status side effects only look at byte lane 0.
  assign start_fire = commit && (req_q.idx == IDX_CTRL) && req_q.strb[0] &&
                      req_q.data[0] && !busy_i;
  assign done_clr   = commit && (req_q.idx == IDX_STATUS) && req_q.strb[0] &&
                      req_q.data[1];

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      start_o  <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      start_o <= start_fire;
      if (done_i)                     done_q <= 1'b1;
      else if (start_fire || done_clr) done_q <= 1'b0;
      if (result_valid_i) result_q <= result_i;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rw_q <= '0;
    end else if (commit) begin
      for (int g = RW_LO; g <= RW_HI; g++) begin
        if (req_q.idx == IDX_W'(g)) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (req_q.strb[b]) rw_q[g][b*8 +: 8] <= req_q.data[b*8 +: 8];
          end
        end
      end
    end
  end

  assign cfg_in_len_o = rw_q[2];
  assign cfg_w_len_o  = rw_q[3];

  // Unmapped words and the self-clearing control word read back as zero.
  always_comb begin
    rd_word = '0;
    if (rd_idx == IDX_RESULT)      rd_word = result_q;
    else if (rd_idx == IDX_STATUS) rd_word = {{(DATA_W-2){1'b0}}, done_q, busy_i};
    for (int i = RW_LO; i <= RW_HI; i++) begin
      if (rd_idx == IDX_W'(i)) rd_word = rw_q[i];
    end
  end

  always_comb begin
    r_nxt = r_st;
    case (r_st)
      R_IDLE:  if (ar_hs) r_nxt = R_DATA;
      R_DATA:  if (axi.s_axi_rready) r_nxt = R_IDLE;
      default: r_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_st      <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      r_st      <= r_nxt;
      arready_q <= (r_nxt == R_IDLE);
      rvalid_q  <= (r_nxt == R_DATA);
      if (ar_hs) rdata_q <= rd_word;
    end
  end

  assign axi.s_axi_awready = awready_q;
  assign axi.s_axi_wready  = wready_q;
  assign axi.s_axi_bvalid  = bvalid_q;
  assign axi.s_axi_bresp   = 2'b00;
  assign axi.s_axi_arready = arready_q;
  assign axi.s_axi_rvalid  = rvalid_q;
  assign axi.s_axi_rdata   = rdata_q;
  assign axi.s_axi_rresp   = 2'b00;
endmodule

// File: tb/tb_ml_acc_axil_regs.sv
// Scoreboard bench for ml_acc_axil_regs: directed scenarios plus random traffic
// checked against a register-map model.
module tb_ml_acc_axil_regs;
  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        start_o;
  logic        busy_i = 1'b0, done_i = 1'b0, result_valid_i = 1'b0;
  logic [31:0] result_i = '0;
  logic [31:0] cfg_in_len_o, cfg_w_len_o;

  ml_acc_axil_regs_if #(.ADDR_W(6), .DATA_W(32)) axi ();

  ml_acc_axil_regs #(.ADDR_W(6), .DATA_W(32)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .axi(axi),
    .start_o(start_o), .busy_i(busy_i), .done_i(done_i),
    .result_valid_i(result_valid_i), .result_i(result_i),
    .cfg_in_len_o(cfg_in_len_o), .cfg_w_len_o(cfg_w_len_o)
  );

  always #5 ACLK = ~ACLK;

  int          errors = 0, checks = 0;
  logic [31:0] rq[$];
  logic [1:0]  bq[$];
  logic [31:0] exp_r;
  logic [1:0]  exp_b;
  int          start_cnt = 0, exp_start = 0;
  logic        start_prev = 1'b0;

  logic [31:0] m_reg[16];
  logic        m_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got no handshake within bound, want one", name);
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_reg[i] = '0;
    m_done = 1'b0;
  endtask

  function automatic logic [31:0] m_read(input logic [3:0] idx);
    if (idx == 4'd1)                              return {30'd0, m_done, busy_i};
    else if (idx == 4'd0 || (idx >= 2 && idx <= 9)) return m_reg[idx];
    else                                          return 32'd0;
  endfunction

  task automatic m_write(input logic [3:0] idx, input logic [31:0] data, input logic [3:0] strb);
    if (idx >= 2 && idx <= 9) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) m_reg[idx][8*b +: 8] = data[8*b +: 8];
    end else if (idx == 4'd1) begin
      if (strb[0] && data[1]) m_done = 1'b0;
    end else if (idx == 4'd10) begin
      if (strb[0] && data[0] && !busy_i) begin
        exp_start++;
        m_done = 1'b0;
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever a response beat is accepted.
  always @(negedge ACLK) begin
    if (!ARESETn) begin
      start_prev = 1'b0;
    end else begin
      if (axi.s_axi_rvalid && axi.s_axi_rready) begin
        if (rq.size() == 0) timeout("rdata_unexpected_beat");
        else begin
          exp_r = rq.pop_front();
          check("rdata", axi.s_axi_rdata, exp_r);
          check("rresp", 32'(axi.s_axi_rresp), 32'd0);
        end
      end
      if (axi.s_axi_bvalid && axi.s_axi_bready) begin
        if (bq.size() == 0) timeout("bresp_unexpected_beat");
        else begin
          exp_b = bq.pop_front();
          check("bresp", 32'(axi.s_axi_bresp), 32'(exp_b));
        end
      end
      if (start_o) begin
        start_cnt++;
        check("start_width", 32'(start_prev), 32'd0);
      end
      start_prev = start_o;
    end
  end

  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly, input bit done_in_commit);
    int t;
    m_write(addr[5:2], data, strb);
    if (done_in_commit) m_done = 1'b1;
    bq.push_back(2'b00);
    fork
      begin
        int ta;
        repeat (aw_dly) step();
        axi.s_axi_awaddr = addr;
        axi.s_axi_awvalid = 1'b1;
        ta = 0;
        do begin @(negedge ACLK); ta++; end while (!axi.s_axi_awready && ta < 40);
        if (ta >= 40) timeout("awready");
        step();
        axi.s_axi_awvalid = 1'b0;
      end
      begin
        int tw;
        repeat (w_dly) step();
        axi.s_axi_wdata = data;
        axi.s_axi_wstrb = strb;
        axi.s_axi_wvalid = 1'b1;
        tw = 0;
        do begin @(negedge ACLK); tw++; end while (!axi.s_axi_wready && tw < 40);
        if (tw >= 40) timeout("wready");
        step();
        axi.s_axi_wvalid = 1'b0;
        if (done_in_commit) begin
          done_i = 1'b1;
          step();
          done_i = 1'b0;
        end
      end
    join
    t = 0;
    do begin @(negedge ACLK); t++; end while (!axi.s_axi_bvalid && t < 40);
    if (t >= 40) timeout("bvalid");
    for (int k = 0; k < b_dly; k++) begin
      step();
      @(negedge ACLK);
      check("bvalid_hold", 32'(axi.s_axi_bvalid), 32'd1);
      check("no_accept_during_b", 32'({axi.s_axi_awready, axi.s_axi_wready}), 32'd0);
    end
    step();
    axi.s_axi_bready = 1'b1;
    @(negedge ACLK);
    step();
    axi.s_axi_bready = 1'b0;
    step();
    check("start_count", 32'(start_cnt), 32'(exp_start));
    check("cfg_in_len", cfg_in_len_o, m_reg[2]);
    check("cfg_w_len", cfg_w_len_o, m_reg[3]);
  endtask

  task automatic axi_read(input logic [5:0] addr, input int r_dly, input bit upd, input logic [31:0] newv);
    int t;
    rq.push_back(m_read(addr[5:2]));
    axi.s_axi_araddr = addr;
    axi.s_axi_arvalid = 1'b1;
    t = 0;
    do begin @(negedge ACLK); t++; end while (!axi.s_axi_arready && t < 40);
    if (t >= 40) timeout("arready");
    if (upd) begin
      result_valid_i = 1'b1;
      result_i = newv;
    end
    step();
    axi.s_axi_arvalid = 1'b0;
    if (upd) begin
      result_valid_i = 1'b0;
      m_reg[0] = newv;
    end
    repeat (r_dly) step();
    axi.s_axi_rready = 1'b1;
    t = 0;
    do begin @(negedge ACLK); t++; end while (!axi.s_axi_rvalid && t < 40);
    if (t >= 40) timeout("rvalid");
    step();
    axi.s_axi_rready = 1'b0;
  endtask

  task automatic core_result(input logic [31:0] v, input bit d);
    result_valid_i = 1'b1;
    result_i = v;
    done_i = d;
    step();
    result_valid_i = 1'b0;
    done_i = 1'b0;
    m_reg[0] = v;
    if (d) m_done = 1'b1;
  endtask

  initial begin
    int t;
    axi.s_axi_awaddr = '0; axi.s_axi_awvalid = 1'b0;
    axi.s_axi_wdata = '0;  axi.s_axi_wstrb = '0; axi.s_axi_wvalid = 1'b0;
    axi.s_axi_bready = 1'b0;
    axi.s_axi_araddr = '0; axi.s_axi_arvalid = 1'b0; axi.s_axi_rready = 1'b0;
    m_reset();

    ARESETn = 1'b0;
    repeat (10) step();
    @(negedge ACLK);
    check("reset_ctrl", 32'({axi.s_axi_awready, axi.s_axi_wready, axi.s_axi_bvalid, axi.s_axi_bresp,
                             axi.s_axi_arready, axi.s_axi_rvalid, axi.s_axi_rresp, start_o}), 32'd0);
    check("reset_rdata", axi.s_axi_rdata, 32'd0);
    check("reset_cfg", cfg_in_len_o | cfg_w_len_o, 32'd0);
    step();
    ARESETn = 1'b1;
    step();
    axi_read(6'h04, 0, 1'b0, '0);

    // Start pulse and self-clearing control word.
    axi_write(6'h28, 32'h1, 4'hF, 0, 0, 0, 1'b0);
    axi_read(6'h28, 1, 1'b0, '0);

    // Result capture, sticky DONE and its clear.
    core_result(32'hD00D1234, 1'b1);
    axi_read(6'h00, 0, 1'b0, '0);
    axi_read(6'h04, 2, 1'b0, '0);
    axi_write(6'h04, 32'h2, 4'hF, 0, 0, 0, 1'b0);
    axi_read(6'h04, 0, 1'b0, '0);

    // W ahead of AW, then byte strobes.
    axi_write(6'h08, 32'hDEADBEEF, 4'hF, 3, 0, 0, 1'b0);
    axi_write(6'h08, 32'h11223344, 4'b0101, 3, 0, 0, 1'b0);
    check("cfg_strb_merge", cfg_in_len_o, 32'hDE22BE44);

    // Start dropped while busy; BREADY withheld.
    busy_i = 1'b1;
    axi_write(6'h28, 32'h1, 4'hF, 0, 0, 5, 1'b0);
    busy_i = 1'b0;

    // done_i coincident with a clear-DONE commit: set wins.
    axi_write(6'h04, 32'h2, 4'hF, 0, 0, 0, 1'b1);
    axi_read(6'h04, 0, 1'b0, '0);

    // Read of reg0 on the same edge as a result update returns the old value.
    axi_read(6'h00, 0, 1'b1, 32'hCAFEF00D);
    axi_read(6'h00, 0, 1'b0, '0);

    // Reset while waiting for W: nothing committed, no response.
    axi.s_axi_awaddr = 6'h08;
    axi.s_axi_awvalid = 1'b1;
    t = 0;
    do begin @(negedge ACLK); t++; end while (!axi.s_axi_awready && t < 40);
    if (t >= 40) timeout("awready_midreset");
    step();
    axi.s_axi_awvalid = 1'b0;
    step();
    ARESETn = 1'b0;
    m_reset();
    repeat (3) begin
      @(negedge ACLK);
      check("no_bvalid_in_reset", 32'({axi.s_axi_bvalid, start_o}), 32'd0);
    end
    step();
    ARESETn = 1'b1;
    step();
    step();
    check("no_bvalid_after_reset", 32'(axi.s_axi_bvalid), 32'd0);
    check("cfg_after_reset", cfg_in_len_o, 32'd0);
    axi_write(6'h08, 32'h0000ABCD, 4'hF, 1, 0, 0, 1'b0);
    check("cfg_after_reset_write", cfg_in_len_o, 32'h0000ABCD);

    for (int i = 0; i < 300; i++) begin
      int op;
      logic [5:0]  a;
      logic [31:0] d;
      busy_i = ($urandom_range(0, 3) == 0);
      step();
      op = $urandom_range(0, 9);
      a = 6'($urandom_range(0, 63));
      d = $urandom;
      if (op <= 4)
        axi_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 2), 1'b0);
      else if (op <= 8)
        axi_read(a, $urandom_range(0, 2), ($urandom_range(0, 7) == 0), $urandom);
      else
        core_result(d, 1'($urandom_range(0, 1)));
    end
    busy_i = 1'b0;
    step();
    step();
    check("rq_drained", 32'(rq.size()), 32'd0);
    check("bq_drained", 32'(bq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
